// File: rtl/pipeline_ctrl.sv
// Pipeline hazard/trap controller: memory stall, branch flush, interrupt entry.
// Optional bus-error timeout in MEM_WAIT enabled by PIPE_CTRL_TIMEOUT_EN.
module pipeline_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 16
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_mem_op,
  input  logic       i_dmem_ack,
  input  logic       i_br_tk,
  input  logic       i_irq,
  input  logic       i_mie,
  output logic       o_dmem_req,
  output logic       o_stall,
  output logic       o_flush,
  output logic       o_trap_take,
  output logic [1:0] o_trap_cause,
  output logic [1:0] o_state
);

  localparam logic [1:0] RUN      = 2'b00;
  localparam logic [1:0] MEM_WAIT = 2'b01;
  localparam logic [1:0] TRAP     = 2'b10;

  localparam logic [1:0] CAUSE_NONE = 2'b00;
  localparam logic [1:0] CAUSE_IRQ  = 2'b01;
  localparam logic [1:0] CAUSE_BUS  = 2'b10;

  if (MEM_TIMEOUT < 2 || MEM_TIMEOUT > 255) begin : g_bad_timeout
    $error("MEM_TIMEOUT must be in 2..255");
  end

  logic [1:0] state_q;
  logic [1:0] state_d;
  logic       timeout;

`ifdef PIPE_CTRL_TIMEOUT_EN
  logic [7:0] cnt_q;

  // Wait counter: zero outside MEM_WAIT, counts unacked wait cycles
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      cnt_q <= 8'd0;
    end else if (state_q != MEM_WAIT) begin
      cnt_q <= 8'd0;
    end else if (!i_dmem_ack && cnt_q != 8'hFF) begin
      cnt_q <= cnt_q + 8'd1;
    end
  end

  assign timeout = (cnt_q == 8'(MEM_TIMEOUT - 1));
`else
  assign timeout = 1'b0;
`endif

  // State register; reset wins from any state
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and all control outputs; reset masks everything
  always_comb begin
    state_d      = state_q;
    o_dmem_req   = 1'b0;
    o_stall      = 1'b0;
    o_flush      = 1'b0;
    o_trap_take  = 1'b0;
    o_trap_cause = CAUSE_NONE;
    o_state      = state_q;
    case (state_q)
      MEM_WAIT: begin
        o_dmem_req = 1'b1;
        if (i_dmem_ack) begin
          o_flush = i_br_tk;
          state_d = RUN;
        end else if (timeout) begin
          o_dmem_req   = 1'b0;
          o_trap_take  = 1'b1;
          o_trap_cause = CAUSE_BUS;
          o_flush      = 1'b1;
          state_d      = TRAP;
        end else begin
          o_stall = 1'b1;
        end
      end
      TRAP: begin
        o_flush = 1'b1;
        state_d = RUN;
      end
      default: begin
        o_dmem_req = i_mem_op;
        if (i_mem_op && !i_dmem_ack) begin
          o_stall = 1'b1;
          state_d = MEM_WAIT;
        end else if (i_irq && i_mie) begin
          o_trap_take  = 1'b1;
          o_trap_cause = CAUSE_IRQ;
          o_flush      = 1'b1;
          state_d      = TRAP;
        end else begin
          o_flush = i_br_tk;
          state_d = RUN;
        end
      end
    endcase
    if (i_rst) begin
      o_dmem_req   = 1'b0;
      o_stall      = 1'b0;
      o_flush      = 1'b0;
      o_trap_take  = 1'b0;
      o_trap_cause = CAUSE_NONE;
      o_state      = RUN;
    end
  end

endmodule
